// File: rtl/homelab_pkg.sv
// Shared Homelab definitions: ioctl upload FSM states and bus widths.
package homelab_pkg;

    localparam int HL_ADDR_W    = 16;
    localparam int IOCTL_ADDR_W = 25;
    localparam logic [7:0] IDX_RAM = 8'h00;

    typedef enum logic [1:0] {
        UL_IDLE,
        UL_HALTING,
        UL_READY,
        UL_FETCH
    } ul_state_t;

endpackage

// File: rtl/homelab_ioctl_upload.sv
// HPS ioctl upload responder: halts the Z80, then serves read strobes
// from Homelab memory with UL_WAIT stalling until each byte is ready.
module homelab_ioctl_upload
    import homelab_pkg::*;
#(
    parameter logic [7:0]           IMG_INDEX = IDX_RAM,
    parameter logic [HL_ADDR_W-1:0] IMG_BASE  = 16'h4000,
    parameter logic [16:0]          IMG_LEN   = 17'h0C000,
    parameter int                   RD_LAT    = 2,
    parameter logic [7:0]           FILL      = 8'hFF
) (
    input  logic                    CLK12,
    input  logic                    RESET_N,
    input  logic                    UL_UPLOAD,
    input  logic                    UL_RD,
    input  logic [IOCTL_ADDR_W-1:0] UL_ADDR,
    input  logic [7:0]              UL_INDEX,
    output logic [7:0]              UL_DIN,
    output logic                    UL_WAIT,
    output logic                    CPU_HALT,
    input  logic                    CPU_HALTED,
    output logic [HL_ADDR_W-1:0]    MEM_ADDR,
    output logic                    MEM_RD,
    input  logic [7:0]              MEM_DATA,
    output logic [7:0]              UL_SUM
);

    localparam logic [1:0] LAT = 2'(RD_LAT);

    ul_state_t             state_q, state_d;
    logic                  upload_q;
    logic [7:0]            din_q, din_d;
    logic                  wait_q, wait_d;
    logic                  halt_q, halt_d;
    logic [HL_ADDR_W-1:0]  maddr_q, maddr_d;
    logic                  rd_q, rd_d;
    logic [7:0]            sum_q, sum_d;
    logic [1:0]            cnt_q, cnt_d;

    logic rise, fall, in_range;

    assign rise = UL_UPLOAD & ~upload_q;
    assign fall = ~UL_UPLOAD & upload_q;

    // High offset bits are checked separately so a huge offset never aliases.
    assign in_range = (UL_INDEX == IMG_INDEX)
                   && (UL_ADDR[24:17] == 8'h00)
                   && (UL_ADDR[16:0] < IMG_LEN);

    always_comb begin
        state_d = state_q;
        din_d   = din_q;
        wait_d  = wait_q;
        halt_d  = halt_q;
        maddr_d = maddr_q;
        rd_d    = 1'b0;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        if (fall) begin
            state_d = UL_IDLE;
            halt_d  = 1'b0;
            wait_d  = 1'b0;
        end else begin
            unique case (state_q)
                UL_IDLE: begin
                    if (rise) begin
                        state_d = UL_HALTING;
                        halt_d  = 1'b1;
                        wait_d  = 1'b1;
                        sum_d   = 8'h00;
                    end
                end
                UL_HALTING: begin
                    if (CPU_HALTED) begin
                        state_d = UL_READY;
                        wait_d  = 1'b0;
                    end else begin
                        wait_d  = 1'b1;
                    end
                end
                UL_READY: begin
                    if (!CPU_HALTED) begin
                        state_d = UL_HALTING;
                        wait_d  = 1'b1;
                    end else if (UL_RD) begin
                        if (in_range) begin
                            state_d = UL_FETCH;
                            maddr_d = IMG_BASE + UL_ADDR[15:0];
                            rd_d    = 1'b1;
                            wait_d  = 1'b1;
                            cnt_d   = LAT;
                        end else begin
                            din_d   = FILL;
                        end
                    end
                end
                UL_FETCH: begin
                    if (!CPU_HALTED) begin
                        state_d = UL_HALTING;
                        wait_d  = 1'b1;
                    end else if (cnt_q == 2'd0) begin
                        state_d = UL_READY;
                        din_d   = MEM_DATA;
                        wait_d  = 1'b0;
                        sum_d   = sum_q + MEM_DATA;
                    end else begin
                        cnt_d   = cnt_q - 2'd1;
                    end
                end
                default: state_d = UL_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK12 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q  <= UL_IDLE;
            upload_q <= 1'b0;
            din_q    <= 8'h00;
            wait_q   <= 1'b0;
            halt_q   <= 1'b0;
            maddr_q  <= '0;
            rd_q     <= 1'b0;
            sum_q    <= 8'h00;
            cnt_q    <= 2'd0;
        end else begin
            state_q  <= state_d;
            upload_q <= UL_UPLOAD;
            din_q    <= din_d;
            wait_q   <= wait_d;
            halt_q   <= halt_d;
            maddr_q  <= maddr_d;
            rd_q     <= rd_d;
            sum_q    <= sum_d;
            cnt_q    <= cnt_d;
        end
    end

    assign UL_DIN   = din_q;
    assign UL_WAIT  = wait_q;
    assign CPU_HALT = halt_q;
    assign MEM_ADDR = maddr_q;
    assign MEM_RD   = rd_q;
    assign UL_SUM   = sum_q;

endmodule

// File: doc/homelab_ioctl_upload.md
Name: homelab_ioctl_upload

Overview:
Upload responder for the HPS ioctl channel. It serves upload read strobes by fetching bytes from the Homelab 16-bit memory space and returning them on UL_DIN, stalling the HPS with UL_WAIT. While an upload is active it halts the Z80 so the RAM image (a save-state or tape-image dump) is read consistently. It sits beside the download path, between the HPS bridge and the Homelab memory arbiter.

Parameters:
IMG_INDEX, 8'h00, ioctl index served; any other index returns filler
IMG_BASE, 16'h4000, Homelab address mapped to upload offset 0
IMG_LEN, 17'h0C000, number of valid bytes; offsets at or beyond this return filler
RD_LAT, 2, memory read latency in CLK12 cycles from MEM_RD to valid MEM_DATA (legal range 1..3)
FILL, 8'hFF, byte returned for out-of-range or foreign-index reads

Ports:
CLK12 in 1 system clock, all logic on the rising edge
RESET_N in 1 asynchronous active-low reset
UL_UPLOAD in 1 level, high for the whole upload session
UL_RD in 1 one-cycle read strobe from the HPS
UL_ADDR in 25 byte offset, valid with UL_RD
UL_INDEX in 8 ioctl index, stable during the session
UL_DIN out 8 returned byte
UL_WAIT out 1 stall to the HPS; it samples UL_DIN only while UL_WAIT=0
CPU_HALT out 1 request to the Z80 bus arbiter
CPU_HALTED in 1 bus granted to this block
MEM_ADDR out 16 memory address
MEM_RD out 1 one-cycle memory read pulse
MEM_DATA in 8 memory read data
UL_SUM out 8 running modulo-256 sum of bytes delivered in the session

Behaviour:
- Reset (async assert, sync release): state=IDLE; UL_DIN=8'h00, UL_WAIT=0, CPU_HALT=0, MEM_ADDR=0, MEM_RD=0, UL_SUM=0.
- Session edges come from a registered copy of UL_UPLOAD.
- States: IDLE, HALTING, READY, FETCH, all one-hot or encoded.
- IDLE: on UL_UPLOAD rising edge -> HALTING next cycle. Same edge sets CPU_HALT=1 and UL_WAIT=1, and clears UL_SUM to 0.
- HALTING: hold UL_WAIT=1 while CPU_HALTED=0. The first cycle with CPU_HALTED=1 -> READY and UL_WAIT=0 on that edge.
- READY, UL_RD=1, in range (UL_INDEX==IMG_INDEX and UL_ADDR<IMG_LEN):
  - Next edge sets MEM_ADDR=IMG_BASE+UL_ADDR[15:0] (modulo 2^16), MEM_RD=1 for exactly one cycle, UL_WAIT=1, state=FETCH.
- FETCH: a down-counter is loaded with RD_LAT. On the edge where it expires:
  - UL_DIN=MEM_DATA and UL_WAIT=0.
  - UL_SUM+=MEM_DATA (8-bit wrap).
  - state -> READY.
  - Strobe-to-data latency is RD_LAT+1 cycles.
- READY, UL_RD=1, out of range:
  - Next edge sets UL_DIN=FILL; UL_WAIT stays 0.
  - No MEM_RD is issued and UL_SUM is not updated.
- UL_RD in IDLE, HALTING or FETCH: ignored with no side effect. No queueing.
- UL_UPLOAD falling edge, from any state:
  - -> IDLE next cycle.
  - CPU_HALT=0 and UL_WAIT=0 on that edge.
  - A FETCH in flight is abandoned: UL_DIN and UL_SUM are unchanged.
  - UL_SUM holds its final value until the next session.
- CPU_HALTED dropping in READY or FETCH (arbiter fault): re-enter HALTING with UL_WAIT=1. A FETCH in flight is abandoned and must be re-requested by the HPS.
- UL_ADDR bits [24:17] nonzero always count as out of range, even when IMG_LEN would wrap.
- RESET_N asserted mid-session: immediate return to reset values, including CPU_HALT=0.

Decomposition:
- Shared package homelab_pkg:
  - state enum ul_state_t {UL_IDLE, UL_HALTING, UL_READY, UL_FETCH}
  - constants HL_ADDR_W=16, IOCTL_ADDR_W=25, IDX_RAM=8'h00
- No sub-module is needed; the latency counter and the range comparator stay inline.
- A single instance is wired into the Homelab top beside the download path.

Test Plan:
1. Halt handshake. Raise UL_UPLOAD with CPU_HALTED held 0 for 5 cycles, then 1 -> CPU_HALT=1 from cycle 1; UL_WAIT=1 through the grant cycle; UL_WAIT=0 on the edge CPU_HALTED is seen; state READY.
2. In-range read. RD_LAT=2, memory preloaded 0x4010=8'hA5; UL_RD with UL_ADDR=0x10 -> MEM_ADDR=16'h4010 with a single MEM_RD pulse; UL_WAIT high 3 cycles; UL_DIN=8'hA5 as UL_WAIT falls; UL_SUM=8'hA5.
3. Filler reads.
   - UL_ADDR=0x0C000 -> UL_DIN=8'hFF next cycle, UL_WAIT never rises, no MEM_RD.
   - UL_INDEX=8'h01, UL_ADDR=0 -> same result.
   - UL_ADDR=25'h1000000 -> same result.
4. Wrap and checksum. IMG_BASE=16'hFFFE; read offsets 0..3 of bytes 01,02,03,04 -> MEM_ADDR sequence FFFE, FFFF, 0000, 0001; UL_SUM=8'h0A. Repeat with bytes 8'h80 x3 -> UL_SUM=8'h80.
5. Abort mid-fetch. Drop UL_UPLOAD one cycle after MEM_RD -> IDLE next cycle; CPU_HALT=0 and UL_WAIT=0; UL_DIN and UL_SUM unchanged. A UL_RD while in IDLE causes no MEM_RD.
6. Reset and arbiter fault.
   - Assert RESET_N low during FETCH -> all outputs reach their reset values without a clock edge.
   - Drop CPU_HALTED in READY -> UL_WAIT=1 until the grant returns.
